// File: rtl/rsa_pkg.sv
// ============================================================================
// rsa_pkg : shared encodings and widths for the RSA arithmetic datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam int RSA_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOP    = 2'd1,
    ST_CORRECT = 2'd2
  } mm_state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_mont_mult.sv
// ============================================================================
// rsa_mont_mult : bit-serial radix-2 Montgomery multiplier, p = a*b*2^-WIDTH mod m
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rsa_mont_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mm_state_t        state, state_nxt;
  logic             load, step, finish;

  logic [WIDTH-1:0] a_sh, b_q, m_q;
  logic [WIDTH+1:0] acc, acc_nxt;
  logic [WIDTH+2:0] t_add;
  logic [CW-1:0]    cnt;
  logic             acc_ge_m;
  logic [WIDTH-1:0] acc_sub;
  logic [WIDTH-1:0] p_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            load      = 1'b1;
            state_nxt = ST_LOOP;
          end
        end
        ST_LOOP: begin
          step = 1'b1;
          if (cnt == LAST_ITER) begin
            state_nxt = ST_CORRECT;
          end
        end
        ST_CORRECT: begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // With T odd and M odd, (T+M)>>1 == (T>>1) + (M>>1) + 1, so the halving is
  // folded ahead of the modulus add and the adder never needs an extra bit.
  always_comb begin
    t_add   = {1'b0, acc} + {3'b000, (a_sh[0] ? b_q : {WIDTH{1'b0}})};
    acc_nxt = t_add[WIDTH+2:1]
            + (t_add[0] ? ({3'b000, m_q[WIDTH-1:1]} + {{(WIDTH+1){1'b0}}, 1'b1})
                        : {(WIDTH+2){1'b0}});
  end

  always_comb begin
    acc_ge_m = (acc >= {2'b00, m_q});
    acc_sub  = acc[WIDTH-1:0] - m_q;
    p_nxt    = acc_ge_m ? acc_sub : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_q  <= '0;
      m_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
      done <= 1'b0;
    end else if (en) begin
      done <= finish;
      if (load) begin
        a_sh <= a;
        b_q  <= b;
        m_q  <= m;
        acc  <= '0;
        cnt  <= '0;
      end
      if (step) begin
        acc  <= acc_nxt;
        a_sh <= a_sh >> 1;
        cnt  <= cnt + CW'(1);
      end
      if (finish) begin
        p <= p_nxt;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rsa_mont_mult.sv
// ============================================================================
// tb_rsa_mont_mult : self-checking bench for rsa_mont_mult against a modular model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rsa_mont_mult;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n, en, start;
  logic [W-1:0] a, b, m;
  logic [W-1:0] p;
  logic         busy, done;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] last_p = '0;

  rsa_mont_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .a     (a),
    .b     (b),
    .m     (m),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: the unique x in [0,M) with x*2^W == A*B (mod M)
  function automatic int mont_ref(input int ia, input int ib, input int im);
    int tgt;
    tgt = (ia * ib) % im;
    for (int x = 0; x < im; x++) begin
      if (((x * (1 << W)) % im) == tgt) return x;
    end
    return -1;
  endfunction

  task automatic do_mult(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im,
                         input int stall_at, input int stall_len,
                         output logic [W-1:0] res, output int lat, output int busy_cycles);
    @(negedge clk);
    a = ia; b = ib; m = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cycles++;
      if (lat == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          lat++;
          vectors++;
          if (busy !== 1'b1 || done !== 1'b0 || p !== last_p) begin
            miscompares++;
            $display("FAIL stall_freeze: busy=%b done=%b p=%0d, required busy=1 done=0 p=%0d",
                     busy, done, p, last_p);
          end
        end
        en = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; start = 1'b0; a = '0; b = '0; m = 7'd97;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: p=%0d busy=%b done=%b, required 0 0 0", p, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_p = '0;
  endtask

  task automatic test_basic();
    logic [W-1:0] res;
    int lat, bc;
    do_mult(7'd5, 7'd7, 7'd97, 0, 0, res, lat, bc);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, required 9", lat);
    end
    vectors++;
    if (res !== 7'd95) begin
      miscompares++;
      $display("FAIL basic_result: got %0d, required 95", res);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, required 8", bc);
    end
    last_p = 7'd95;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== 7'd95) begin
      miscompares++;
      $display("FAIL basic_idle_hold: done=%b busy=%b p=%0d, required 0 0 95", done, busy, p);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{7'd31, 7'd1,  7'd96, 7'd0};
    logic [W-1:0] vb [4] = '{7'd50, 7'd1,  7'd96, 7'd80};
    logic [W-1:0] ve [4] = '{7'd50, 7'd72, 7'd72, 7'd0};
    logic [W-1:0] res;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_mult(va[i], vb[i], 7'd97, 0, 0, res, lat, bc);
      vectors++;
      if (res !== ve[i] || lat !== 9) begin
        miscompares++;
        $display("FAIL vector_%0d: p=%0d lat=%0d, required p=%0d lat=9", i, res, lat, ve[i]);
      end
      last_p = ve[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_p;
    logic [W-1:0] na, nb;
    int cnt;
    @(negedge clk);
    a = 7'd0; b = 7'd80; m = 7'd97; start = 1'b1;
    exp_p = 7'(mont_ref(0, 80, 97));
    @(posedge clk); #1;
    cnt = 1;
    for (int r = 0; r < 4; r++) begin
      // operand changes while busy must not disturb the latched multiply
      a = 7'($urandom); b = 7'($urandom);
      while (done !== 1'b1 && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      vectors++;
      if (cnt !== 9 || p !== exp_p) begin
        miscompares++;
        $display("FAIL b2b_%0d: p=%0d cycles=%0d, required p=%0d cycles=9", r, p, cnt, exp_p);
      end
      last_p = exp_p;
      na = 7'($urandom_range(0, 96));
      nb = 7'($urandom_range(0, 96));
      a = na; b = nb;
      if (r == 3) start = 1'b0;
      exp_p = 7'(mont_ref(int'(na), int'(nb), 97));
      @(posedge clk); #1;
      cnt = 1;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] res;
    int lat, bc;
    do_mult(7'd5, 7'd7, 7'd97, 3, 3, res, lat, bc);
    vectors++;
    if (lat !== 12 || res !== 7'd95) begin
      miscompares++;
      $display("FAIL stall_result: p=%0d lat=%0d, required p=95 lat=12", res, lat);
    end
    last_p = 7'd95;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int lat, bc;
    logic saw_done;
    @(negedge clk);
    a = 7'd9; b = 7'd11; m = 7'd97; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_state: p=%0d busy=%b done=%b, required 0 0 0", p, busy, done);
    end
    last_p = '0;
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abandon: activity=%b, required 0", saw_done);
    end
    do_mult(7'd5, 7'd7, 7'd97, 0, 0, res, lat, bc);
    vectors++;
    if (res !== 7'd95 || lat !== 9) begin
      miscompares++;
      $display("FAIL reset_mid_restart: p=%0d lat=%0d, required p=95 lat=9", res, lat);
    end
    last_p = 7'd95;
  endtask

  task automatic test_random();
    logic [W-1:0] res, ra, rb, rm, exp_p;
    int lat, bc;
    for (int i = 0; i < 25; i++) begin
      rm = 7'(2 * $urandom_range(1, 63) + 1);
      ra = 7'($urandom_range(0, int'(rm) - 1));
      rb = 7'($urandom_range(0, int'(rm) - 1));
      exp_p = 7'(mont_ref(int'(ra), int'(rb), int'(rm)));
      do_mult(ra, rb, rm, 0, 0, res, lat, bc);
      vectors++;
      if (res !== exp_p || lat !== 9) begin
        miscompares++;
        $display("FAIL random_%0d: a=%0d b=%0d m=%0d p=%0d lat=%0d, required p=%0d lat=9",
                 i, ra, rb, rm, res, lat, exp_p);
      end
      last_p = exp_p;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
